// File: rtl/ray_stream_adapter.sv
// ray_stream_adapter: gathers eight 32-bit AXI4-Stream beats into one 256-bit
// ray record and queues finished rays in a first-word-fall-through FIFO that
// feeds the traversal core's empty_n / rd_data / rd_en read port.
// Frames with the wrong length are dropped and counted, and they set a sticky error flag.
module ray_stream_adapter #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic              ray_stream_empty_n,
    output logic [255:0]      ray_stream_rd_data,
    input  logic              ray_stream_rd_en,
    output logic              frame_err,
    output logic [CNT_W-1:0]  ray_count,
    output logic [CNT_W-1:0]  err_count
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_COLLECT, S_HOLD, S_DISCARD} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_rdy;
    logic [2:0]          r_idx;
    logic [255:0]        r_asm;
    logic [255:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [FCNT_W-1:0]   r_fcount;
    logic                r_frame_err;
    logic [CNT_W-1:0]    r_ray_count;
    logic [CNT_W-1:0]    r_err_count;

    logic                w_beat;
    logic                w_collect_beat;
    logic                w_short_err;
    logic                w_long_err;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_nonempty;

    assign w_full     = (r_fcount == FCNT_W'(FIFO_DEPTH));
    assign w_nonempty = (r_fcount != '0);
    assign w_beat     = s_axis_tvalid && s_axis_tready;
    assign w_pop      = ray_stream_rd_en && w_nonempty;

    // FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_COLLECT;
        else          r_state <= w_next_state;
    end

    // FSM next-state: a frame ending exactly on beat 8 is held for the FIFO,
    // while a frame running past beat 8 is drained until its tlast
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_COLLECT: if (w_beat && r_idx == 3'd7)
                           w_next_state = s_axis_tlast ? S_HOLD : S_DISCARD;
            S_HOLD:    if (!w_full) w_next_state = S_COLLECT;
            S_DISCARD: if (w_beat && s_axis_tlast) w_next_state = S_COLLECT;
            default:   w_next_state = S_COLLECT;
        endcase
    end

    // FSM outputs: handshake ready, FIFO push and framing-error strobes
    always_comb begin
        s_axis_tready  = r_rdy && (r_state == S_COLLECT || r_state == S_DISCARD);
        w_collect_beat = (r_state == S_COLLECT) && w_beat;
        w_short_err    = w_collect_beat && (r_idx != 3'd7) && s_axis_tlast;
        w_long_err     = w_collect_beat && (r_idx == 3'd7) && !s_axis_tlast;
        w_push         = (r_state == S_HOLD) && !w_full;
    end

    // tready stays low through reset and rises on the first edge after release
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_rdy <= 1'b0;
        else          r_rdy <= 1'b1;
    end

    // Beat index: a short frame restarts at 0, and beat 8 wraps 7 -> 0
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)            r_idx <= '0;
        else if (w_short_err)    r_idx <= '0;
        else if (w_collect_beat) r_idx <= r_idx + 3'd1;
    end

    // Ray assembly: beat k lands at bits [32k +: 32]; dropped frames are overwritten later
    always_ff @(posedge aclk) begin
        if (w_collect_beat) r_asm[32*r_idx +: 32] <= s_axis_tdata;
    end

    // FIFO storage write; reads are gated by empty_n, so the storage needs no reset
    always_ff @(posedge aclk) begin
        if (w_push) r_mem[r_wptr] <= r_asm;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_fcount <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_fcount <= r_fcount + FCNT_W'(1);
                2'b01:   r_fcount <= r_fcount - FCNT_W'(1);
                default: r_fcount <= r_fcount;
            endcase
        end
    end

    // Status: sticky framing flag and wrapping ray/error counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_frame_err <= 1'b0;
            r_ray_count <= '0;
            r_err_count <= '0;
        end else begin
            if (w_short_err || w_long_err) begin
                r_frame_err <= 1'b1;
                r_err_count <= r_err_count + CNT_W'(1);
            end
            if (w_push) r_ray_count <= r_ray_count + CNT_W'(1);
        end
    end

    assign ray_stream_empty_n = w_nonempty;
    assign ray_stream_rd_data = w_nonempty ? r_mem[r_rptr] : '0;
    assign frame_err          = r_frame_err;
    assign ray_count          = r_ray_count;
    assign err_count          = r_err_count;

endmodule

// File: tb/tb_ray_stream_adapter.sv
// Testbench for ray_stream_adapter: random ray frames are checked against a
// queue-based model of the expected rays and the expected ray and error counts.
module tb_ray_stream_adapter;
    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [31:0]  s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic         ray_stream_empty_n;
    logic [255:0] ray_stream_rd_data;
    logic         ray_stream_rd_en = 1'b0;
    logic         frame_err;
    logic [31:0]  ray_count;
    logic [31:0]  err_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [255:0] mq[$];
    int           m_rays;
    int           m_errs;

    ray_stream_adapter #(.FIFO_DEPTH(4), .CNT_W(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .ray_stream_empty_n(ray_stream_empty_n), .ray_stream_rd_data(ray_stream_rd_data),
        .ray_stream_rd_en(ray_stream_rd_en), .frame_err(frame_err),
        .ray_count(ray_count), .err_count(err_count)
    );

    always #5 aclk = ~aclk;

    task automatic do_reset();
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        ray_stream_rd_en = 1'b0;
        mq.delete();
        m_rays = 0;
        m_errs = 0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit last);
        int t = 0;
        s_axis_tdata = d;
        s_axis_tlast = last;
        s_axis_tvalid = 1'b1;
        while (s_axis_tready !== 1'b1 && t < 60) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 60) begin
            n_checks++;
            $display("FAIL beat_timeout: tready=%b after %0d cycles, required 1", s_axis_tready, t);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
    endtask

    // Sends n beats with tlast on beat n; updates the model: 8 beats -> ray, else error
    task automatic send_frame(input int n);
        logic [255:0] ray = '0;
        logic [31:0]  d;
        for (int k = 0; k < n; k++) begin
            d = $urandom;
            if (k < 8) ray[32*k +: 32] = d;
            send_beat(d, k == n - 1);
        end
        if (n == 8) begin
            mq.push_back(ray);
            m_rays++;
        end else begin
            m_errs++;
        end
    endtask

    // Waits for a ray at the head, compares it with the model and pops it
    task automatic pop_check(input string name);
        int t = 0;
        logic [255:0] exp;
        while (ray_stream_empty_n !== 1'b1 && t < 40) begin
            @(posedge aclk);
            #1;
            t++;
        end
        exp = (mq.size() > 0) ? mq.pop_front() : '0;
        n_checks++;
        if (ray_stream_empty_n !== 1'b1 || ray_stream_rd_data !== exp)
            $display("FAIL %s: empty_n=%b rd_data=%h, required empty_n=1 rd_data=%h",
                     name, ray_stream_empty_n, ray_stream_rd_data, exp);
        else n_pass++;
        ray_stream_rd_en = 1'b1;
        @(posedge aclk);
        #1;
        ray_stream_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_checks++;
        if (s_axis_tready !== 1'b0 || ray_stream_empty_n !== 1'b0 || ray_stream_rd_data !== '0 ||
            frame_err !== 1'b0 || ray_count !== 32'd0 || err_count !== 32'd0)
            $display("FAIL reset_vals: tready=%b empty_n=%b rd_data=%h ferr=%b rc=%0d ec=%0d, required all 0",
                     s_axis_tready, ray_stream_empty_n, ray_stream_rd_data, frame_err, ray_count, err_count);
        else n_pass++;
        aresetn = 1'b1;
        #1;
        n_checks++;
        if (s_axis_tready !== 1'b0) $display("FAIL reset_release_tready: got %b, required 0", s_axis_tready);
        else n_pass++;
        @(posedge aclk);
        #1;
        n_checks++;
        if (s_axis_tready !== 1'b1) $display("FAIL reset_first_edge_tready: got %b, required 1", s_axis_tready);
        else n_pass++;
    endtask

    task automatic test_single_ray();
        logic [31:0] f [8] = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000};
        logic [255:0] exp = '0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            exp[32*k +: 32] = f[k];
            send_beat(f[k], k == 7);
        end
        n_checks++;
        if (ray_stream_empty_n !== 1'b0 || s_axis_tready !== 1'b0)
            $display("FAIL single_hold_cycle: empty_n=%b tready=%b, required 0 0", ray_stream_empty_n, s_axis_tready);
        else n_pass++;
        @(posedge aclk);
        #1;
        n_checks++;
        if (ray_stream_empty_n !== 1'b1 || ray_stream_rd_data[31:0] !== 32'h3f800000 ||
            ray_stream_rd_data[255:224] !== 32'h41000000 || ray_stream_rd_data !== exp)
            $display("FAIL single_ray_data: empty_n=%b rd_data=%h, required 1 %h", ray_stream_empty_n, ray_stream_rd_data, exp);
        else n_pass++;
        n_checks++;
        if (ray_count !== 32'd1 || s_axis_tready !== 1'b1)
            $display("FAIL single_ray_count: rc=%0d tready=%b, required 1 1", ray_count, s_axis_tready);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int r = 0; r < 5; r++) send_frame(8);
        repeat (3) @(posedge aclk);
        #1;
        n_checks++;
        if (s_axis_tready !== 1'b0 || ray_count !== 32'd4)
            $display("FAIL bp_full_hold: tready=%b rc=%0d, required 0 4", s_axis_tready, ray_count);
        else n_pass++;
        pop_check("bp_first_pop");
        n_checks++;
        if (ray_count !== 32'd4 || s_axis_tready !== 1'b0)
            $display("FAIL bp_no_bypass: rc=%0d tready=%b, required 4 0", ray_count, s_axis_tready);
        else n_pass++;
        @(posedge aclk);
        #1;
        n_checks++;
        if (ray_count !== 32'd5 || s_axis_tready !== 1'b1)
            $display("FAIL bp_release: rc=%0d tready=%b, required 5 1", ray_count, s_axis_tready);
        else n_pass++;
        for (int r = 0; r < 4; r++) pop_check("bp_drain");
        n_checks++;
        if (ray_stream_empty_n !== 1'b0) $display("FAIL bp_empty_after: empty_n=%b, required 0", ray_stream_empty_n);
        else n_pass++;
    endtask

    task automatic test_short_frame();
        do_reset();
        send_frame(3);
        send_frame(8);
        @(posedge aclk);
        #1;
        n_checks++;
        if (frame_err !== 1'b1 || err_count !== 32'(m_errs) || ray_count !== 32'(m_rays))
            $display("FAIL short_counts: ferr=%b ec=%0d rc=%0d, required 1 %0d %0d", frame_err, err_count, ray_count, m_errs, m_rays);
        else n_pass++;
        pop_check("short_valid_ray");
        n_checks++;
        if (ray_stream_empty_n !== 1'b0) $display("FAIL short_only_one: empty_n=%b, required 0", ray_stream_empty_n);
        else n_pass++;
    endtask

    task automatic test_long_frame();
        do_reset();
        send_frame(10);
        send_frame(8);
        @(posedge aclk);
        #1;
        n_checks++;
        if (frame_err !== 1'b1 || err_count !== 32'd1 || ray_count !== 32'd1)
            $display("FAIL long_counts: ferr=%b ec=%0d rc=%0d, required 1 1 1", frame_err, err_count, ray_count);
        else n_pass++;
        pop_check("long_next_ray");
    endtask

    task automatic test_push_pop();
        logic [255:0] head;
        do_reset();
        send_frame(8);
        send_frame(8);
        @(posedge aclk);
        #1;
        send_frame(8);
        head = mq.pop_front();
        n_checks++;
        if (ray_stream_rd_data !== head) $display("FAIL pp_head: rd_data=%h, required %h", ray_stream_rd_data, head);
        else n_pass++;
        ray_stream_rd_en = 1'b1;
        @(posedge aclk);
        #1;
        ray_stream_rd_en = 1'b0;
        n_checks++;
        if (ray_count !== 32'd3 || ray_stream_rd_data !== mq[0])
            $display("FAIL pp_advance: rc=%0d rd_data=%h, required 3 %h", ray_count, ray_stream_rd_data, mq[0]);
        else n_pass++;
        pop_check("pp_second");
        pop_check("pp_third");
        n_checks++;
        if (ray_stream_empty_n !== 1'b0) $display("FAIL pp_count_two: empty_n=%b, required 0", ray_stream_empty_n);
        else n_pass++;
    endtask

    task automatic test_reset_mid_ray();
        do_reset();
        send_frame(8);
        for (int k = 0; k < 4; k++) send_beat($urandom, 1'b0);
        aresetn = 1'b0;
        #2;
        n_checks++;
        if (ray_stream_empty_n !== 1'b0 || ray_count !== 32'd0 || err_count !== 32'd0 || s_axis_tready !== 1'b0)
            $display("FAIL midrst_clear: empty_n=%b rc=%0d ec=%0d tready=%b, required 0 0 0 0",
                     ray_stream_empty_n, ray_count, err_count, s_axis_tready);
        else n_pass++;
        do_reset();
        ray_stream_rd_en = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        ray_stream_rd_en = 1'b0;
        n_checks++;
        if (ray_stream_empty_n !== 1'b0 || ray_stream_rd_data !== '0)
            $display("FAIL rd_en_empty: empty_n=%b rd_data=%h, required 0 0", ray_stream_empty_n, ray_stream_rd_data);
        else n_pass++;
        send_frame(8);
        pop_check("midrst_clean_ray");
        n_checks++;
        if (ray_count !== 32'd1 || err_count !== 32'd0 || frame_err !== 1'b0 || ray_stream_empty_n !== 1'b0)
            $display("FAIL midrst_counts: rc=%0d ec=%0d ferr=%b empty_n=%b, required 1 0 0 0",
                     ray_count, err_count, frame_err, ray_stream_empty_n);
        else n_pass++;
    endtask

    task automatic test_random_stream();
        int lens [6] = '{8, 8, 8, 3, 10, 1};
        int n;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            n = lens[$urandom_range(0, 5)];
            if (n == 8 && mq.size() >= 4) pop_check("rand_pop");
            send_frame(n);
        end
        @(posedge aclk);
        #1;
        n_checks++;
        if (ray_count !== 32'(m_rays) || err_count !== 32'(m_errs) || frame_err !== (m_errs > 0))
            $display("FAIL rand_counts: rc=%0d ec=%0d ferr=%b, required %0d %0d %b",
                     ray_count, err_count, frame_err, m_rays, m_errs, m_errs > 0);
        else n_pass++;
        while (mq.size() > 0) pop_check("rand_drain");
        n_checks++;
        if (ray_stream_empty_n !== 1'b0) $display("FAIL rand_empty: empty_n=%b, required 0", ray_stream_empty_n);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_ray();
        test_back_pressure();
        test_short_frame();
        test_long_frame();
        test_push_pop();
        test_reset_mid_ray();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
